mii_frame_generator: RTL and testbench

Free-running transmit-side traffic source for the 1.6T MII datapath. After reset it emits an endless, deterministic stream of frames: an inter-frame gap of IDLE words, a START word, a fixed-length payload, and an EOF word. It has no inputs besides clock and reset. It drives the TX MII interface in place of a MAC, for bring-up and loopback testing of downstream PCS logic.

---
 rtl/mii_gen_pkg.sv | 33 +++
 rtl/mii_gen_payload.sv | 75 +++++++
 rtl/mii_frame_generator.sv | 130 +++++++++++++
 tb/tb_mii_frame_generator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mii_gen_pkg.sv
// Shared types, constants and helpers for the MII frame generator.
// No ports. Contents: FSM state enum, preamble/SFD bytes, LFSR taps/seed,
// byte-replication and LFSR-step helper functions.
package mii_gen_pkg;

    // Widest bus that replicate_byte() can fill. Callers narrow the result with a cast.
    localparam int unsigned MAX_DATA_WIDTH = 2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_EOF   = 2'd3
    } mii_gen_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // x^8+x^6+x^5+x^4+1 taps on state bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'hFF;

    // One byte copied into every lane of a MAX_DATA_WIDTH word.
    function automatic logic [MAX_DATA_WIDTH-1:0] replicate_byte(input logic [7:0] b);
        return {(MAX_DATA_WIDTH / 8){b}};
    endfunction

    // One left shift of the Fibonacci LFSR.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mii_gen_payload.sv
// Payload word source for the MII frame generator.
// Build option: MII_GEN_PRBS_PAYLOAD_EN selects LFSR bytes instead of a byte index.
// Ports:
//   clk, i_rst   clock, async active-low reset
//   advance      a payload word is consumed this cycle
//   frame_start  START word is emitted this cycle (restarts the byte index)
//   payload_c    combinational payload word for the current DATA slot
module mii_gen_payload
    import mii_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  advance,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] payload_c
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

`ifdef MII_GEN_PRBS_PAYLOAD_EN

    logic [7:0] lfsr;
    logic [7:0] lfsr_next_c;
    logic       unused_frame_start;

    // The sequence runs on across frames, so frame boundaries are ignored.
    assign unused_frame_start = frame_start;

    // Lanes take consecutive LFSR states; the word's final state seeds the next word.
    always_comb begin
        logic [7:0] s;
        s = lfsr;
        payload_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            payload_c[i*8 +: 8] = s;
            s = lfsr_step(s);
        end
        lfsr_next_c = s;
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_next_c;
        end
    end

`else

    // Byte index of lane 0 for the current word, modulo 256.
    logic [7:0] base;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            base <= '0;
        end else if (frame_start) begin
            base <= '0;
        end else if (advance) begin
            base <= base + 8'(LANES);
        end
    end

    always_comb begin
        payload_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            payload_c[i*8 +: 8] = base + 8'(i);
        end
    end

`endif

endmodule

// File: rtl/mii_frame_generator.sv
// Free-running TX MII traffic source: IDLE gap, START, fixed payload, EOF, forever.
// Build option: MII_GEN_PRBS_PAYLOAD_EN (LFSR payload, see mii_gen_payload).
// Ports:
//   clk        clock
//   i_rst      async active-low reset (output forced to the IDLE word)
//   o_tx_data  registered TX data, lane 0 in bits [7:0]
//   o_tx_ctrl  registered control flags (whole-word or per-lane)
module mii_frame_generator
    import mii_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CTRL_WIDTH  = 1,
    parameter int unsigned IDLE_LENGTH = 16,
    parameter int unsigned DATA_LENGTH = 64,
    parameter logic [7:0]  IDLE_CODE   = 8'h07,
    parameter logic [7:0]  START_CODE  = 8'hFB,
    parameter logic [7:0]  EOF_CODE    = 8'hFD
) (
    input  logic                  clk,
    input  logic                  i_rst,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl
);

    localparam int unsigned LANES      = DATA_WIDTH / 8;
    localparam int unsigned DATA_WORDS = DATA_LENGTH / LANES;
    localparam int unsigned MAX_LEN    = (IDLE_LENGTH > DATA_WORDS) ? IDLE_LENGTH : DATA_WORDS;
    localparam int unsigned CNT_W      = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LENGTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WORDS - 1);

    // Lane 0 = first, top lane = last, every lane in between = fill.
    function automatic logic [DATA_WIDTH-1:0] marker_word(input logic [7:0] first,
                                                          input logic [7:0] fill,
                                                          input logic [7:0] last);
        logic [DATA_WIDTH-1:0] w;
        w = DATA_WIDTH'(replicate_byte(fill));
        w[DATA_WIDTH-1 -: 8] = last;
        w[7:0] = first;
        return w;
    endfunction

    localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(replicate_byte(IDLE_CODE));
    localparam logic [DATA_WIDTH-1:0] START_WORD = marker_word(START_CODE, PREAMBLE_BYTE, SFD_BYTE);
    localparam logic [DATA_WIDTH-1:0] EOF_WORD   = marker_word(EOF_CODE, IDLE_CODE, IDLE_CODE);

    mii_gen_state_e        state;
    mii_gen_state_e        next_state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [DATA_WIDTH-1:0] word_c;
    logic [CTRL_WIDTH-1:0] ctrl_c;
    logic [DATA_WIDTH-1:0] payload_c;
    logic                  advance_c;
    logic                  frame_start_c;

    mii_gen_payload #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_payload (
        .clk         (clk),
        .i_rst       (i_rst),
        .advance     (advance_c),
        .frame_start (frame_start_c),
        .payload_c   (payload_c)
    );

    // state/cnt name the word loaded into the output registers on the next edge.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            o_tx_data <= IDLE_WORD;
            o_tx_ctrl <= '1;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            o_tx_data <= word_c;
            o_tx_ctrl <= ctrl_c;
        end
    end

    // Next-state and word selection; CTRL_WIDTH'(1) is both the whole-word flag and "lane 0 only".
    always_comb begin
        next_state    = state;
        next_cnt      = cnt;
        word_c        = IDLE_WORD;
        ctrl_c        = '1;
        advance_c     = 1'b0;
        frame_start_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cnt == IDLE_LAST) begin
                    next_state = ST_START;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            ST_START: begin
                word_c        = START_WORD;
                ctrl_c        = CTRL_WIDTH'(1);
                frame_start_c = 1'b1;
                next_state    = ST_DATA;
                next_cnt      = '0;
            end
            ST_DATA: begin
                word_c    = payload_c;
                ctrl_c    = '0;
                advance_c = 1'b1;
                if (cnt == DATA_LAST) begin
                    next_state = ST_EOF;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            ST_EOF: begin
                word_c     = EOF_WORD;
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mii_frame_generator.sv
// Directed bench for mii_frame_generator: a default instance (64-bit, 1 flag,
// 8 payload words) and a per-lane-flag instance with a single payload word.
module tb_mii_frame_generator;

    localparam int IDLE_LEN = 16;
    localparam int D_A      = 8;
    localparam int D_B      = 1;
    localparam int PERIOD_A = IDLE_LEN + D_A + 2;
    localparam int PERIOD_B = IDLE_LEN + D_B + 2;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] EOF_W   = 64'h07070707070707FD;

    logic        clk;
    logic        i_rst;
    logic [63:0] data_a;
    logic [0:0]  ctrl_a;
    logic [63:0] data_b;
    logic [7:0]  ctrl_b;

    int          tests;
    int          fails;
    int          edge_cnt;
    int          last_start;
    logic [7:0]  lfsr_a;
    logic [7:0]  lfsr_b;

    mii_frame_generator dut_a (
        .clk       (clk),
        .i_rst     (i_rst),
        .o_tx_data (data_a),
        .o_tx_ctrl (ctrl_a)
    );

    mii_frame_generator #(
        .CTRL_WIDTH  (8),
        .DATA_LENGTH (8)
    ) dut_b (
        .clk       (clk),
        .i_rst     (i_rst),
        .o_tx_data (data_b),
        .o_tx_ctrl (ctrl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected word/flags for position pos within a frame period (pos 0 = first IDLE).
    function automatic void model_word(input int pos, input int d_words, input bit per_lane,
                                       inout logic [7:0] lfsr,
                                       output logic [63:0] data, output logic [7:0] ctrl);
        data = IDLE_W;
        ctrl = per_lane ? 8'hFF : 8'h01;
        if (pos == IDLE_LEN) begin
            data = START_W;
            ctrl = 8'h01;
        end else if (pos > IDLE_LEN && pos <= IDLE_LEN + d_words) begin
            ctrl = 8'h00;
            for (int i = 0; i < 8; i++) begin
`ifdef MII_GEN_PRBS_PAYLOAD_EN
                data[i*8 +: 8] = lfsr;
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
                data[i*8 +: 8] = 8'((pos - IDLE_LEN - 1) * 8 + i);
`endif
            end
        end else if (pos == IDLE_LEN + d_words + 1) begin
            data = EOF_W;
        end
    endfunction

    // Advance n clock edges, checking both instances against the model after each.
    task automatic run_edges(input int n);
        logic [63:0] ed;
        logic [7:0]  ec;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_cnt++;
            model_word((edge_cnt - 1) % PERIOD_A, D_A, 1'b0, lfsr_a, ed, ec);
            chk($sformatf("a_data@%0d", edge_cnt), data_a, ed);
            chk($sformatf("a_ctrl@%0d", edge_cnt), {63'b0, ctrl_a}, {56'b0, ec});
            model_word((edge_cnt - 1) % PERIOD_B, D_B, 1'b1, lfsr_b, ed, ec);
            chk($sformatf("b_data@%0d", edge_cnt), data_b, ed);
            chk($sformatf("b_ctrl@%0d", edge_cnt), {56'b0, ctrl_b}, {56'b0, ec});
            if (data_a === START_W && ctrl_a === 1'b1) begin
                if (last_start > 0)
                    chk($sformatf("start_gap@%0d", edge_cnt), 64'(edge_cnt - last_start), 64'd26);
                last_start = edge_cnt;
            end
        end
    endtask

    task automatic model_reset();
        edge_cnt   = 0;
        last_start = 0;
        lfsr_a     = 8'hFF;
        lfsr_b     = 8'hFF;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        i_rst = 1'b0;

        // Reset held low.
        #23;
        chk("rst_data_a", data_a, IDLE_W);
        chk("rst_ctrl_a", {63'b0, ctrl_a}, 64'd1);
        chk("rst_data_b", data_b, IDLE_W);
        chk("rst_ctrl_b", {56'b0, ctrl_b}, 64'hFF);
        @(negedge clk);
        i_rst = 1'b1;

        // First frame with hand-computed words.
        run_edges(16);
        run_edges(1);
        chk("start_a", data_a, 64'hD5555555555555FB);
        chk("start_ctrl_a", {63'b0, ctrl_a}, 64'd1);
        chk("start_ctrl_b", {56'b0, ctrl_b}, 64'h01);
        run_edges(1);
`ifdef MII_GEN_PRBS_PAYLOAD_EN
        chk("prbs_first_byte", {56'b0, data_a[7:0]}, 64'hFF);
`else
        chk("first_data_a", data_a, 64'h0706050403020100);
        chk("only_data_b", data_b, 64'h0706050403020100);
`endif
        chk("data_ctrl_a", {63'b0, ctrl_a}, 64'd0);
        chk("data_ctrl_b", {56'b0, ctrl_b}, 64'h00);
        run_edges(1);
        chk("eof_b", data_b, 64'h07070707070707FD);
        chk("eof_ctrl_b", {56'b0, ctrl_b}, 64'hFF);
        run_edges(6);
`ifndef MII_GEN_PRBS_PAYLOAD_EN
        chk("last_data_a", data_a, 64'h3F3E3D3C3B3A3938);
`endif
        run_edges(1);
        chk("eof_a", data_a, 64'h07070707070707FD);
        chk("eof_ctrl_a", {63'b0, ctrl_a}, 64'd1);

        // Long run: periodicity and repeated payload via the model.
        run_edges(274);

        // Land on a DATA word (frame position 20), then reset between edges.
        run_edges(7);
        chk("mid_data_ctrl_a", {63'b0, ctrl_a}, 64'd0);
        #2;
        i_rst = 1'b0;
        #1;
        chk("abort_data_a", data_a, IDLE_W);
        chk("abort_ctrl_a", {63'b0, ctrl_a}, 64'd1);
        chk("abort_ctrl_b", {56'b0, ctrl_b}, 64'hFF);
        model_reset();
        @(negedge clk);
        i_rst = 1'b1;

        // Restart from edge 1 after the abort.
        run_edges(17);
        chk("restart_start_a", data_a, 64'hD5555555555555FB);
        run_edges(1);
`ifndef MII_GEN_PRBS_PAYLOAD_EN
        chk("restart_data_a", data_a, 64'h0706050403020100);
`endif
        run_edges(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
